// File: rtl/ps2_ascii_keyboard_if.sv
// PS/2 keyboard-side pins plus the character/error strobes towards the terminal.
// The keyboard block is the slave: it consumes the PS/2 pins and drives the strobes.
interface ps2_ascii_keyboard_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       add_char;
    logic [6:0] char_value;
    logic       frame_error;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  add_char,
        input  char_value,
        input  frame_error
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output add_char,
        output char_value,
        output frame_error
    );
endinterface

// File: rtl/ps2_ascii_keyboard.sv
// PS/2 keyboard receiver (scan code set 2) with make/break, extended, shift and
// caps-lock tracking; emits one-cycle ASCII strobes and frame error strobes.
module ps2_ascii_keyboard #(
    parameter int unsigned TIMEOUT_BITS   = 13,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_ascii_keyboard_if.slave  kbd
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] TO_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    // {hit, alpha, lower/unshifted, upper/shifted}
    function automatic logic [15:0] ent(input logic alpha, input logic [7:0] lo,
                                        input logic [7:0] hi);
        return {1'b1, alpha, lo[6:0], hi[6:0]};
    endfunction

    function automatic logic [15:0] key_lookup(input logic [7:0] code);
        logic [15:0] r;
        r = '0;
        case (code)
            8'h1C: r = ent(1'b1, "a", "A");
            8'h32: r = ent(1'b1, "b", "B");
            8'h21: r = ent(1'b1, "c", "C");
            8'h23: r = ent(1'b1, "d", "D");
            8'h24: r = ent(1'b1, "e", "E");
            8'h2B: r = ent(1'b1, "f", "F");
            8'h34: r = ent(1'b1, "g", "G");
            8'h33: r = ent(1'b1, "h", "H");
            8'h43: r = ent(1'b1, "i", "I");
            8'h3B: r = ent(1'b1, "j", "J");
            8'h42: r = ent(1'b1, "k", "K");
            8'h4B: r = ent(1'b1, "l", "L");
            8'h3A: r = ent(1'b1, "m", "M");
            8'h31: r = ent(1'b1, "n", "N");
            8'h44: r = ent(1'b1, "o", "O");
            8'h4D: r = ent(1'b1, "p", "P");
            8'h15: r = ent(1'b1, "q", "Q");
            8'h2D: r = ent(1'b1, "r", "R");
            8'h1B: r = ent(1'b1, "s", "S");
            8'h2C: r = ent(1'b1, "t", "T");
            8'h3C: r = ent(1'b1, "u", "U");
            8'h2A: r = ent(1'b1, "v", "V");
            8'h1D: r = ent(1'b1, "w", "W");
            8'h22: r = ent(1'b1, "x", "X");
            8'h35: r = ent(1'b1, "y", "Y");
            8'h1A: r = ent(1'b1, "z", "Z");
            8'h45: r = ent(1'b0, "0", ")");
            8'h16: r = ent(1'b0, "1", "!");
            8'h1E: r = ent(1'b0, "2", "@");
            8'h26: r = ent(1'b0, "3", "#");
            8'h25: r = ent(1'b0, "4", "$");
            8'h2E: r = ent(1'b0, "5", "%");
            8'h36: r = ent(1'b0, "6", "^");
            8'h3D: r = ent(1'b0, "7", "&");
            8'h3E: r = ent(1'b0, "8", "*");
            8'h46: r = ent(1'b0, "9", "(");
            8'h0E: r = ent(1'b0, 8'h60, "~");
            8'h4E: r = ent(1'b0, "-", "_");
            8'h55: r = ent(1'b0, "=", "+");
            8'h54: r = ent(1'b0, "[", "{");
            8'h5B: r = ent(1'b0, "]", "}");
            8'h5D: r = ent(1'b0, "\\", "|");
            8'h4C: r = ent(1'b0, ";", ":");
            8'h52: r = ent(1'b0, "'", "\"");
            8'h41: r = ent(1'b0, ",", "<");
            8'h49: r = ent(1'b0, ".", ">");
            8'h4A: r = ent(1'b0, "/", "?");
            8'h29: r = ent(1'b0, 8'h20, 8'h20);
            8'h5A: r = ent(1'b0, 8'h0A, 8'h0A);
            8'h66: r = ent(1'b0, 8'h08, 8'h08);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Synchroniser stages reset to the idle-high line level so reset release
    // never looks like a falling edge.
    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
    logic ps2_data_s1_q, ps2_data_s2_q;

    state_t                  state_q, state_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_reg_q, shift_reg_d;
    logic                    parity_q, parity_d;
    logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d;
    logic                    brk_q, brk_d;
    logic                    ext_q, ext_d;
    logic                    shift_l_q, shift_l_d;
    logic                    shift_r_q, shift_r_d;
    logic                    caps_q, caps_d;
    logic                    add_char_q, add_char_d;
    logic [6:0]              char_value_q, char_value_d;
    logic                    frame_error_q, frame_error_d;

    logic        fall;
    logic        din;
    logic        byte_ok;
    logic        err;
    logic        emit;
    logic [6:0]  emit_val;
    logic [15:0] lk;
    logic        shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
        end else begin
            ps2_clk_s1_q   <= kbd.ps2_clk;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_clk_prev_q <= ps2_clk_s2_q;
            ps2_data_s1_q  <= kbd.ps2_data;
            ps2_data_s2_q  <= ps2_data_s1_q;
        end
    end

    always_comb begin
        fall  = ps2_clk_prev_q & ~ps2_clk_s2_q;
        din   = ps2_data_s2_q;
        shift = shift_l_q | shift_r_q;
        lk    = key_lookup(shift_reg_q);

        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_reg_d   = shift_reg_q;
        parity_d      = parity_q;
        timeout_d     = timeout_q;
        brk_d         = brk_q;
        ext_d         = ext_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        caps_d        = caps_q;
        char_value_d  = char_value_q;
        byte_ok       = 1'b0;
        err           = 1'b0;
        emit          = 1'b0;
        emit_val      = '0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!din) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_reg_d = {din, shift_reg_q[7:1]};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = din;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (din && (^{shift_reg_q, parity_q})) byte_ok = 1'b1;
                    else                                   err     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame transitions only happen on an edge, so the timeout branch never
        // competes with them.
        if (state_q == ST_IDLE) begin
            timeout_d = '0;
        end else if (fall) begin
            timeout_d = '0;
        end else if (timeout_q == TO_LIMIT) begin
            timeout_d = '0;
            state_d   = ST_IDLE;
            err       = 1'b1;
        end else begin
            timeout_d = timeout_q + 1'b1;
        end

        if (byte_ok) begin
            if (shift_reg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_reg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (ext_q) begin
                    if (!brk_q && shift_reg_q == 8'h5A) begin
                        emit     = 1'b1;
                        emit_val = 7'h0A;
                    end else if (!brk_q && shift_reg_q == 8'h4A) begin
                        emit     = 1'b1;
                        emit_val = 7'h2F;
                    end
                end else begin
                    case (shift_reg_q)
                        8'h12: shift_l_d = ~brk_q;
                        8'h59: shift_r_d = ~brk_q;
                        8'h58: if (!brk_q) caps_d = ~caps_q;
                        default: begin
                            if (!brk_q && lk[15]) begin
                                emit = 1'b1;
                                if (lk[14]) emit_val = (shift ^ caps_q) ? lk[6:0] : lk[13:7];
                                else        emit_val = shift ? lk[6:0] : lk[13:7];
                            end
                        end
                    endcase
                end
            end
        end

        if (err) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end

        add_char_d    = emit;
        frame_error_d = err;
        if (emit) char_value_d = emit_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_reg_q   <= '0;
            parity_q      <= 1'b0;
            timeout_q     <= '0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            shift_l_q     <= 1'b0;
            shift_r_q     <= 1'b0;
            caps_q        <= 1'b0;
            add_char_q    <= 1'b0;
            char_value_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_reg_q   <= shift_reg_d;
            parity_q      <= parity_d;
            timeout_q     <= timeout_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            caps_q        <= caps_d;
            add_char_q    <= add_char_d;
            char_value_q  <= char_value_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign kbd.add_char    = add_char_q;
    assign kbd.char_value  = char_value_q;
    assign kbd.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_ascii_keyboard.sv
// Directed bench for ps2_ascii_keyboard: bit-banged PS/2 frames, strobes
// collected on the falling clk edge and compared against hand-derived ASCII.
module tb_ps2_ascii_keyboard;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_ascii_keyboard_if kbd ();

    ps2_ascii_keyboard #(
        .TIMEOUT_BITS   (13),
        .TIMEOUT_CYCLES (5000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kbd   (kbd.slave)
    );

    int         total = 0;
    int         bad   = 0;
    logic [6:0] got[$];
    logic [6:0] exp[$];
    int         err_seen = 0;
    int         lat;
    int         lat_cnt;
    logic       prev_add = 1'b0;
    logic       prev_fe  = 1'b0;

    // Strobe collector; also flags back-to-back strobes.
    always @(negedge clk) begin
        if (reset) begin
            if (kbd.add_char) got.push_back(kbd.char_value);
            if (kbd.frame_error) err_seen++;
            if (kbd.add_char || kbd.frame_error) begin
                total++;
                if ((kbd.add_char && prev_add) || (kbd.frame_error && prev_fe)) begin
                    bad++;
                    $display("FAIL strobe_spacing: add=%b/%b err=%b/%b, want no repeat",
                             prev_add, kbd.add_char, prev_fe, kbd.frame_error);
                end
            end
        end
        prev_add = kbd.add_char;
        prev_fe  = kbd.frame_error;
    end

    // One PS/2 bit: data set while clock high, clock low for 20 cycles.
    task automatic ps2_bit(input logic b);
        @(negedge clk);
        kbd.ps2_data = b;
        repeat (10) @(negedge clk);
        kbd.ps2_clk = 1'b0;
        lat = -1;
        lat_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            lat_cnt++;
            if (lat < 0 && (kbd.add_char || kbd.frame_error)) lat = lat_cnt;
        end
        kbd.ps2_clk = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ flip_par);
        ps2_bit(stop);
        kbd.ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b1);
    endtask

    task automatic clear_obs();
        got.delete();
        exp.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        kbd.ps2_clk  = 1'b1;
        kbd.ps2_data = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (kbd.add_char !== 1'b0) begin
            bad++; $display("FAIL reset_add_char: got %b want 0", kbd.add_char);
        end
        total++;
        if (kbd.frame_error !== 1'b0) begin
            bad++; $display("FAIL reset_frame_error: got %b want 0", kbd.frame_error);
        end
        total++;
        if (kbd.char_value !== 7'h00) begin
            bad++; $display("FAIL reset_char_value: got %h want 00", kbd.char_value);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_char();
        clear_obs();
        send(8'h1C);
        exp = '{7'h61};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL single_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL single_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if (err_seen != 0) begin
            bad++; $display("FAIL single_err: got %0d want 0", err_seen);
        end
        clear_obs();
        send(8'h1C);
        total++;
        if (lat != 3) begin
            bad++; $display("FAIL single_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_shift_sequence();
        clear_obs();
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        exp = '{7'h41, 7'h61};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL shift_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL shift_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_caps_lock();
        clear_obs();
        send(8'h58); send(8'hF0); send(8'h58);
        send(8'h12); send(8'h16);
        send(8'hF0); send(8'h12); send(8'h15);
        send(8'h16);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        exp = '{7'h21, 7'h51, 7'h31, 7'h61, 7'h61};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL caps_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL caps_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_punct_control();
        clear_obs();
        send(8'h59);
        send(8'h4E); send(8'h5D); send(8'h52); send(8'h5A); send(8'h29);
        send(8'hF0); send(8'h59);
        send(8'h0E); send(8'h5D); send(8'h4A); send(8'h66); send(8'h13);
        exp = '{7'h5F, 7'h7C, 7'h22, 7'h0A, 7'h20, 7'h60, 7'h5C, 7'h2F, 7'h08};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL punct_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL punct_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_frame_errors();
        clear_obs();
        send_frame(8'h1C, 1'b1, 1'b1);
        total++;
        if (err_seen != 1 || got.size() != 0) begin
            bad++; $display("FAIL parity_err: got err=%0d chars=%0d want err=1 chars=0",
                            err_seen, got.size());
        end
        total++;
        if (lat != 3) begin
            bad++; $display("FAIL parity_err_latency: got %0d want 3", lat);
        end
        send(8'h29);
        send_frame(8'h1C, 1'b0, 1'b0);
        total++;
        if (err_seen != 2) begin
            bad++; $display("FAIL stop_err: got %0d want 2", err_seen);
        end
        send(8'hF0);
        send_frame(8'h32, 1'b1, 1'b1);
        send(8'h1C);
        exp = '{7'h20, 7'h61};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL ferr_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL ferr_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if (err_seen != 3) begin
            bad++; $display("FAIL ferr_total: got %0d want 3", err_seen);
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        kbd.ps2_data = 1'b1;
        repeat (4900) @(negedge clk);
        total++;
        if (err_seen != 0) begin
            bad++; $display("FAIL timeout_early: got %0d want 0", err_seen);
        end
        repeat (200) @(negedge clk);
        total++;
        if (err_seen != 1) begin
            bad++; $display("FAIL timeout_fire: got %0d want 1", err_seen);
        end
        send(8'h66);
        exp = '{7'h08};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL timeout_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL timeout_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_extended();
        clear_obs();
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'h4A);
        send(8'hE0); send(8'h12); send(8'h1C);
        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'h1C);
        exp = '{7'h0A, 7'h2F, 7'h61, 7'h61};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL ext_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL ext_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send(8'h1C); send(8'h32); send(8'h21);
        exp = '{7'h61, 7'h62, 7'h63};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL b2b_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (kbd.char_value !== 7'h00 || kbd.add_char !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: got val=%h add=%b want 00/0",
                            kbd.char_value, kbd.add_char);
        end
        reset = 1'b1;
        kbd.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h45);
        exp = '{7'h30};
        total++;
        if (got.size() != exp.size()) begin
            bad++; $display("FAIL midreset_count: got %0d want %0d", got.size(), exp.size());
        end else foreach (exp[i]) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++; $display("FAIL midreset_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        total++;
        if (err_seen != 0) begin
            bad++; $display("FAIL midreset_err: got %0d want 0", err_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_shift_sequence();
        test_caps_lock();
        test_punct_control();
        test_frame_errors();
        test_timeout();
        test_extended();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_keyboard.md
Name: ps2_ascii_keyboard

Overview:
Upstream source for the ASCII terminal. Receives PS/2 keyboard frames (scan code set 2), checks them, and tracks make/break, extended, shift and caps-lock state. Converts key presses to 7-bit ASCII. Emits a single-cycle add_char strobe with char_value, which connect directly to the terminal's add_char/char_value inputs; there is no backpressure.

Parameters:
TIMEOUT_BITS, 13, width of inter-edge timeout counter
TIMEOUT_CYCLES, 5000, clk cycles without a PS/2 clock falling edge before a partial frame is abandoned (200 us at 25 MHz)

Ports:
clk  input  1  system clock (25 MHz nominal, same as the VGA domain)
reset  input  1  asynchronous, active-low reset; asserted low clears all state
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous
ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous
add_char  output  1  one-cycle strobe: char_value is valid
char_value  output  7  ASCII code; held until the next strobe
frame_error  output  1  one-cycle strobe: bad start, parity or stop bit, or timeout

Behaviour:
- Reset (low, async):
  - Outputs: add_char=0, frame_error=0, char_value=0.
  - State: FSM=IDLE, bit count=0, timeout=0, break/extended/shift_l/shift_r/caps flags=0.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops.
  - Falling edge = synchronised clock was 1 last cycle and is 0 now.
  - Data is sampled on that same cycle.
- Frame FSM (states advance only on falling edges):
  - IDLE: edge with data=0 -> DATA, count=0. Edge with data=1 -> frame_error, stay in IDLE.
  - DATA: shift data in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: the frame is good if the stop bit is 1 and the 9 bits (data + parity) have odd total parity. Good -> pass the byte to the decoder. Bad -> frame_error. Either way -> IDLE.
- Timeout:
  - The counter clears on every falling edge and on entering IDLE, and increments otherwise while not in IDLE.
  - When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE, frame_error pulses, and the partial byte is discarded.
- Any frame error or timeout also clears the break and extended flags. Shift and caps flags keep their values.
- Decoder (same cycle as a good byte):
  - E0: set extended; no output.
  - F0: set break; no output.
  - Otherwise handle the byte as a key code, then clear both break and extended.
  - Shift keys: 12 (left) / 59 (right) drive shift_l / shift_r. Make sets the flag, break clears it. shift = shift_l | shift_r.
  - Caps lock: 58 make toggles caps. Break on 58 does nothing; auto-repeat makes toggle each time.
  - Breaks of all other keys produce no output.
  - Make of a mapped key: add_char=1 in the next cycle (latency = 1 clk after the stop-bit edge), with char_value registered in the same cycle.
  - Unmapped codes and unmapped extended codes produce nothing.
- Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Uppercase when shift XOR caps, else lowercase.
- Digits (unshifted/shifted), caps has no effect:
  - 45 0/), 16 1/!, 1E 2/@, 26 3/#, 25 4/$, 2E 5/%, 36 6/^, 3D 7/&, 3E 8/*, 46 9/(.
- Punctuation (unshifted/shifted), caps has no effect:
  - 0E `/~, 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|, 4C ;/:, 52 '/", 41 ,/<, 49 ./>, 4A //?.
- Control keys:
  - 29 -> 20 (space), 5A -> 0A (newline), 66 -> 08 (backspace).
  - These are independent of shift.
- Extended keys: E0 5A -> 0A; E0 4A -> 2F. All other extended codes are ignored. This includes E0 12 (fake shift), which must not change shift state.
- Strobe spacing: add_char and frame_error are never asserted 2 cycles in a row. Frames are at least 11 PS/2 bit times apart.
- Glitch rejection is not provided beyond the synchroniser. The keyboard-to-host direction only; the block never drives ps2_clk or ps2_data.

Test Plan:
- Frame 1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> add_char 1 cycle after the stop edge, char_value=0x61; frame_error stays 0.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> two strobes: 0x41 then 0x61. No strobes for the shift or break codes.
- 58, F0 58, 16 (shift held via 12) -> char_value 0x21. Then release shift and send 15 -> 0x51 (caps active).
- Frame 1C with parity bit flipped -> frame_error pulse, no add_char. Next good 29 -> 0x20.
- 5 bits of a frame, then idle for 5000 clk -> frame_error at the timeout. A following full 66 frame -> 0x08.
- E0 5A -> 0x0A; E0 12 then 1C -> 0x61 (shift unaffected). Assert reset mid-frame, release, send 45 -> 0x30 with no stale bits.
